// File: rtl/lector_gray.sv
// Slide-switch Gray front end: two-flop resynchronizer, whole-word debounce,
// Gray-to-binary conversion, and registered change/jump flags.
module lector_gray #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WIDTH           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_estable,
  output logic [WIDTH-1:0] bin,
  output logic             cambio,
  output logic             salto
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] candidato_q, candidato_d;
  logic [WIDTH-1:0] estable_q, estable_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CntW-1:0]  contador_q, contador_d;
  logic             cambio_q, cambio_d;
  logic             salto_q, salto_d;
  logic [WIDTH-1:0] diff;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign diff = candidato_q ^ estable_q;

  always_comb begin
    candidato_d = candidato_q;
    estable_d   = estable_q;
    bin_d       = bin_q;
    contador_d  = contador_q;
    cambio_d    = 1'b0;
    salto_d     = salto_q;
    if (sync2_q != candidato_q) begin
      candidato_d = sync2_q;
      contador_d  = '0;
    end else if (candidato_q == estable_q) begin
      contador_d = '0;
    end else if (contador_q == CntMax) begin
      estable_d  = candidato_q;
      bin_d      = g2b(candidato_q);
      cambio_d   = 1'b1;
      // More than one bit set means a non-adjacent Gray step.
      salto_d    = (diff & (diff - WIDTH'(1))) != '0;
      contador_d = '0;
    end else begin
      contador_d = contador_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      candidato_q <= '0;
      estable_q   <= '0;
      bin_q       <= '0;
      contador_q  <= '0;
      cambio_q    <= 1'b0;
      salto_q     <= 1'b0;
    end else begin
      sync1_q     <= gray_in;
      sync2_q     <= sync1_q;
      candidato_q <= candidato_d;
      estable_q   <= estable_d;
      bin_q       <= bin_d;
      contador_q  <= contador_d;
      cambio_q    <= cambio_d;
      salto_q     <= salto_d;
    end
  end

  assign gray_estable = estable_q;
  assign bin          = bin_q;
  assign cambio       = cambio_q;
  assign salto        = salto_q;

endmodule

// File: tb/tb_lector_gray.sv
// Bench for lector_gray: directed steps plus random holds, checked every cycle
// against a run-length model of the debounce rules.
module tb_lector_gray;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gray_in;
  logic [3:0] gray_estable, bin;
  logic       cambio, salto;

  int n_cmp = 0;
  int n_bad = 0;

  lector_gray #(
    .DEBOUNCE_CYCLES(D),
    .WIDTH          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .gray_in     (gray_in),
    .gray_estable(gray_estable),
    .bin         (bin),
    .cambio      (cambio),
    .salto       (salto)
  );

  always #5 clk = ~clk;

  // Reference model: the word seen by the debouncer is the input sampled two
  // edges earlier; it is accepted on the edge where it has been seen for D+1
  // consecutive edges while differing from the accepted word.
  logic [3:0] m_d1, m_d2, m_prev, m_stable, m_bin;
  logic       m_cambio, m_salto;
  int         m_run;

  function automatic logic [3:0] gray_index(input logic [3:0] g);
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      if ((v ^ (v >> 1)) == g) return v;
    end
    return 4'h0;
  endfunction

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_prev = 0; m_stable = 0; m_bin = 0;
    m_cambio = 0; m_salto = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic [3:0] g);
    logic [3:0] seen;
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = g;
    if (seen != m_prev) m_run = 1;
    else m_run = m_run + 1;
    m_prev   = seen;
    m_cambio = 1'b0;
    if (seen != m_stable && m_run == int'(D) + 1) begin
      m_salto  = $countones(seen ^ m_stable) > 1;
      m_stable = seen;
      m_bin    = gray_index(seen);
      m_cambio = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("estable", gray_estable, m_stable);
    chk("bin", bin, m_bin);
    chk("cambio", {3'b0, cambio}, {3'b0, m_cambio});
    chk("salto", {3'b0, salto}, {3'b0, m_salto});
  endtask

  // Drive at the falling edge, let one rising edge happen, sample at the next falling edge.
  task automatic tick(input logic [3:0] g);
    gray_in = g;
    @(posedge clk);
    if (reset) model_edge(g);
    @(negedge clk);
    check_model();
  endtask

  // Hold g for 7 edges and check the accept lands exactly on the 7th.
  task automatic step_accept(input string tag, input logic [3:0] g, input logic [3:0] exp_bin,
                             input logic exp_salto);
    for (int i = 0; i < int'(D) + 2; i++) begin
      tick(g);
      chk({tag, "_early"}, {3'b0, cambio}, 4'h0);
    end
    tick(g);
    chk({tag, "_estable"}, gray_estable, g);
    chk({tag, "_bin"}, bin, exp_bin);
    chk({tag, "_cambio"}, {3'b0, cambio}, 4'h1);
    chk({tag, "_salto"}, {3'b0, salto}, {3'b0, exp_salto});
    tick(g);
    chk({tag, "_pulse_end"}, {3'b0, cambio}, 4'h0);
  endtask

  initial begin
    logic [3:0] g;
    int hold;
    model_reset();
    reset   = 1'b0;
    gray_in = 4'b0110;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick(4'b0110);
      chk("rst_bin", bin, 4'h0);
    end
    reset = 1'b1;

    step_accept("first", 4'b0110, 4'b0100, 1'b1);
    step_accept("adj", 4'b0111, 4'b0101, 1'b0);

    for (int i = 0; i < 20; i++) begin
      tick(((i / 2) % 2 == 0) ? 4'b0101 : 4'b0111);
      chk("bounce_cambio", {3'b0, cambio}, 4'h0);
    end
    step_accept("settle", 4'b0101, 4'b0110, 1'b0);

    for (int i = 0; i < 3; i++) tick(4'b1101);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0101);
      chk("glitch_cambio", {3'b0, cambio}, 4'h0);
    end
    chk("glitch_estable", gray_estable, 4'b0101);

    step_accept("jump", 4'b1000, 4'b1111, 1'b1);
    for (int i = 0; i < 16; i++) begin
      g = 4'(i);
      step_accept("sweep", g ^ (g >> 1), 4'(i), 1'b0);
    end

    // Reset two cycles into a count, asserted between clock edges.
    for (int i = 0; i < 4; i++) tick(4'b0110);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_estable", gray_estable, 4'h0);
    chk("midrst_bin", bin, 4'h0);
    chk("midrst_flags", {2'b0, cambio, salto}, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    step_accept("postrst", 4'b0110, 4'b0100, 1'b1);

    for (int s = 0; s < 120; s++) begin
      g    = 4'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 9));
      for (int i = 0; i < hold; i++) tick(g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lector_gray.md
Name: lector_gray

Overview:
- Input-side front end of the Gray decoder. Captures the four raw slide-switch lines carrying a Gray code and resynchronizes them to clk.
- Debounces them as a single 4-bit word and converts the accepted word to binary.
- Produces the registered binary value consumed by the 7-segment display path, a one-cycle change strobe, and a non-adjacent-jump flag.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles the synchronized word must hold before acceptance (10 ms at 100 MHz); legal range >= 2.
- WIDTH, 4, Gray/binary word width; only 4 is verified.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- gray_in  input  WIDTH  raw switch lines, asynchronous to clk, may bounce
- gray_estable  output  WIDTH  last accepted debounced Gray word
- bin  output  WIDTH  binary equivalent of gray_estable, registered
- cambio  output  1  one-cycle pulse, high the cycle after a new word is accepted
- salto  output  1  registered with cambio; 1 if the accepted word differs from the previous accepted word in more than one bit

Behaviour:
- All flops reset asynchronously when reset = 0:
  - sync1, sync2, candidato, gray_estable, bin = 0
  - contador = 0, cambio = 0, salto = 0
  - Release is sampled synchronously.
- Synchronizer: gray_in -> sync1 -> sync2, two flops per bit. No logic between the stages.
- Debounce counter: contador is $clog2(DEBOUNCE_CYCLES) bits wide. Each rising edge, in priority order:
  1. If sync2 != candidato: candidato <= sync2, contador <= 0.
  2. Else if candidato == gray_estable: contador <= 0 (idle).
  3. Else if contador == DEBOUNCE_CYCLES-1 (accept):
     - gray_estable <= candidato
     - bin <= g2b(candidato)
     - cambio <= 1
     - salto <= (popcount(candidato ^ gray_estable) > 1)
     - contador <= 0
  4. Else: contador <= contador + 1.
- cambio: forced 0 on every edge that does not accept. It is a single-cycle pulse and never stays high for two consecutive cycles. salto holds its value until the next accept.
- Conversion: bin[3] = g[3]; bin[i] = bin[i+1] ^ g[i], for i = 2..0.
- Latency: a clean step on gray_in held steady appears on gray_estable/bin after exactly DEBOUNCE_CYCLES+3 rising edges, with cambio high during the following cycle.
- Bounce handling:
  - Any change of sync2 during the count restarts the count from 0 with the new candidate.
  - If the input returns to gray_estable before acceptance, no update occurs and cambio does not pulse.
- Multi-bit change: bits are debounced as one word. A multi-bit change that settles produces exactly one accept. salto = 1 if the Gray distance to the previous word is > 1.
- After reset: if gray_in != 0, the first accept occurs DEBOUNCE_CYCLES+3 edges after release, with a cambio pulse. salto is computed against 0.
- Reset mid-count: all state clears immediately. The count restarts from scratch after release.
- contador never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Outputs are purely registered, with no combinational path from gray_in.

Test Plan:
- Bench runs with DEBOUNCE_CYCLES = 4.
- Reset held low with gray_in = 4'b0110 -> all outputs 0 during reset. After release, at edge 7: gray_estable = 0110, bin = 0100, cambio pulses 1 cycle, salto = 1 (0000 -> 0110 is 2 bits).
- From stable 0110, set gray_in = 0111 cleanly -> after 7 edges: bin = 0101, cambio single pulse, salto = 0.
- Toggle gray_in between 0111 and 0101 every 2 cycles for 20 cycles, then hold 0101 -> no cambio during bouncing. One accept 7 edges after the last change: bin = 0110, salto = 0.
- Glitch: change gray_in 0101 -> 1101 for 3 cycles, then back to 0101 -> no update, cambio never asserted, gray_estable stays 0101.
- Set gray_in = 1000 -> bin = 1111, salto = 1 (0101 ^ 1000 has 3 bits set). Then sweep all 16 Gray codes in sequence -> bin counts 0..15 and salto = 0 on every step.
- Assert reset low 2 cycles into a debounce count -> outputs clear asynchronously (mid-cycle). After release, the full DEBOUNCE_CYCLES+3 latency applies.
